dmem_responder: RTL

Data-memory responder on the far end of the memory-stage load/store request interface. It accepts one request at a time from the memory pipeline stage, inserts a programmable number of wait states, and performs byte-enabled reads and writes on a local doubleword SRAM. It returns load data sign- or zero-extended, or reports load/store address-misaligned and access faults. Its stall output is what holds the memory stage, and therefore the pipeline behind it, while a request is outstanding.

---
 rtl/dmem_pkg.sv | 72 +++++++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM state
// encoding and the byte-lane helpers used on both the store and load paths.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // One bit per byte touched by an access of the given size, right-aligned.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Byte enables for an access of the given size at doubleword offset off.
    function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [2:0] off);
        return size_mask(size) << off;
    endfunction

    // Address not a multiple of the access size.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        logic m;
        case (size)
            SZ_B:    m = 1'b0;
            SZ_H:    m = off[0];
            SZ_W:    m = |off[1:0];
            default: m = |off;
        endcase
        return m;
    endfunction

    // Copy right-aligned store data into every lane so any byte enable finds it.
    function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] d);
        logic [63:0] r;
        case (size)
            SZ_B:    r = {8{d[7:0]}};
            SZ_H:    r = {4{d[15:0]}};
            SZ_W:    r = {2{d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Pick the addressed lanes out of a doubleword and sign/zero extend them.
    function automatic logic [63:0] extend_load(input logic [63:0] dw, input logic [2:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [63:0] r;
        sh = dw >> {off, 3'b000};
        case (size)
            SZ_B:    r = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    r = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    r = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port doubleword SRAM with per-byte write enables. Write and read
// are both synchronous; contents and read register are never reset.
module dmem_array #(
    parameter int DEPTH_DW = 1024,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [7:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem_r [DEPTH_DW];
    logic [63:0] q_r;

    // Byte-enabled write and registered read of the addressed doubleword.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem_r[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            q_r <= mem_r[idx];
        end
    end

    assign rdata = q_r;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: accepts one request at a time, waits a
// fixed number of cycles, then accesses the local SRAM or reports a fault.
// BASE_ADDR is expected to be doubleword aligned.
module dmem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_DW    = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_V,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [63:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    input  logic [63:0] REQ_WDATA,
    output logic        RSP_V,
    output logic [63:0] RSP_RDATA,
    output logic        RSP_LAM,
    output logic        RSP_LAF,
    output logic        RSP_SAM,
    output logic        RSP_SAF,
    output logic        DMEM_STALL
);

    import dmem_pkg::*;

    localparam int         AW      = $clog2(DEPTH_DW);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [63:0] addr_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [63:0] wdata_r;
    logic        rsp_v_r;
    logic        rsp_load_r;
    logic        lam_r;
    logic        laf_r;
    logic        sam_r;
    logic        saf_r;

    logic          accept_s;
    logic [63:0]   cur_addr_s;
    logic [63:0]   cur_off_s;
    logic          cur_we_s;
    logic [1:0]    cur_size_s;
    logic [63:0]   cur_wdata_s;
    logic          mis_s;
    logic          acc_s;
    logic          fault_s;
    logic          go_resp_s;
    logic          mem_we_s;
    logic          mem_re_s;
    logic [7:0]    mem_be_s;
    logic [63:0]   mem_wdata_s;
    logic [AW-1:0] mem_idx_s;
    logic [63:0]   mem_q_s;

    // Select the live request in IDLE (zero-wait accesses use it directly)
    // or the latched one otherwise, and derive faults and SRAM controls.
    always_comb begin
        accept_s = (state_r == IDLE) && REQ_V;
        if (state_r == IDLE) begin
            cur_addr_s  = REQ_ADDR;
            cur_we_s    = REQ_WE;
            cur_size_s  = REQ_SIZE;
            cur_wdata_s = REQ_WDATA;
        end else begin
            cur_addr_s  = addr_r;
            cur_we_s    = we_r;
            cur_size_s  = size_r;
            cur_wdata_s = wdata_r;
        end
        cur_off_s = cur_addr_s - BASE_ADDR;
        mis_s     = misaligned(cur_addr_s[2:0], cur_size_s);
        // An aligned access never crosses a doubleword, so checking the
        // doubleword index against the array bounds covers every byte.
        acc_s     = (cur_addr_s < BASE_ADDR) | (|cur_off_s[63:AW+3]);
        fault_s   = mis_s | acc_s;
        if (accept_s) begin
            go_resp_s = fault_s | NO_WAIT;
        end else if ((state_r == WAIT) && (cnt_r == 4'd0)) begin
            go_resp_s = 1'b1;
        end else begin
            go_resp_s = 1'b0;
        end
        mem_we_s    = RESET & go_resp_s & cur_we_s & ~fault_s;
        mem_re_s    = RESET & go_resp_s & ~cur_we_s & ~fault_s;
        mem_be_s    = byte_enable(cur_size_s, cur_off_s[2:0]);
        mem_wdata_s = replicate(cur_size_s, cur_wdata_s);
        mem_idx_s   = cur_off_s[AW+2:3];
    end

    // Request FSM: latch on acceptance, count wait states, pulse the response.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            we_r       <= 1'b0;
            addr_r     <= 64'd0;
            size_r     <= 2'd0;
            uns_r      <= 1'b0;
            wdata_r    <= 64'd0;
            rsp_v_r    <= 1'b0;
            rsp_load_r <= 1'b0;
            lam_r      <= 1'b0;
            laf_r      <= 1'b0;
            sam_r      <= 1'b0;
            saf_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (REQ_V) begin
                        we_r    <= REQ_WE;
                        addr_r  <= REQ_ADDR;
                        size_r  <= REQ_SIZE;
                        uns_r   <= REQ_UNSIGNED;
                        wdata_r <= REQ_WDATA;
                        lam_r   <= ~REQ_WE & mis_s;
                        laf_r   <= ~REQ_WE & ~mis_s & acc_s;
                        sam_r   <= REQ_WE & mis_s;
                        saf_r   <= REQ_WE & ~mis_s & acc_s;
                        if (fault_s || NO_WAIT) begin
                            state_r    <= RESP;
                            rsp_v_r    <= 1'b1;
                            rsp_load_r <= ~REQ_WE & ~fault_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r    <= RESP;
                        rsp_v_r    <= 1'b1;
                        rsp_load_r <= ~we_r;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    rsp_v_r    <= 1'b0;
                    rsp_load_r <= 1'b0;
                    lam_r      <= 1'b0;
                    laf_r      <= 1'b0;
                    sam_r      <= 1'b0;
                    saf_r      <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    rsp_v_r    <= 1'b0;
                    rsp_load_r <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_DW (DEPTH_DW),
        .AW       (AW)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .be    (mem_be_s),
        .idx   (mem_idx_s),
        .wdata (mem_wdata_s),
        .rdata (mem_q_s)
    );

    assign REQ_READY  = (state_r == IDLE);
    assign RSP_V      = rsp_v_r;
    assign RSP_RDATA  = rsp_load_r ? extend_load(mem_q_s, addr_r[2:0], size_r, uns_r) : 64'd0;
    assign RSP_LAM    = lam_r;
    assign RSP_LAF    = laf_r;
    assign RSP_SAM    = sam_r;
    assign RSP_SAF    = saf_r;
    assign DMEM_STALL = accept_s | (state_r == WAIT);

endmodule
